// File: rtl/mult_pkg.sv
// Shared constants for the pipelined multiplier: operand width bounds and pipeline depth.
package mult_pkg;

  localparam int unsigned WidthDefault = 8;
  localparam int unsigned WidthMin     = 4;
  localparam int unsigned WidthMax     = 32;
  localparam int unsigned NumStages    = 3;

endpackage

// File: rtl/adder_cell.sv
// One-bit full adder; the building block of the carry-save reduction tree.
module adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pipelined_multi.sv
// Three-stage valid/ready multiplier: partial products, carry-save reduction, final add.
// Signed operands use Baugh-Wooley sign correction so one array serves both modes.
module pipelined_multi
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = WidthDefault,
  parameter int unsigned STAGES = NumStages
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]   inb,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result_out
);

  localparam int unsigned PW = 2 * WIDTH;
  // Baugh-Wooley constant: +2^WIDTH + 2^(2*WIDTH-1), only applied in signed mode.
  localparam logic [PW-1:0] Corr = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  if (STAGES != NumStages) begin : g_bad_stages
    $error("pipelined_multi: STAGES must be 3");
  end
  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_width
    $error("pipelined_multi: WIDTH out of range 4..32");
  end

  // Handshake: each stage loads when empty or when its contents move on this cycle.
  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  assign en3       = !v3_q || out_ready;
  assign en2       = !v2_q || en3;
  assign en1       = !v1_q || en2;
  assign in_ready  = en1;
  assign out_valid = v3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
    end
  end

  // Stage 1: AND array, inverting cross terms that involve exactly one sign bit.
  logic [WIDTH-1:0] pp_d [WIDTH];
  logic [WIDTH-1:0] pp_q [WIDTH];
  logic             sgn1_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
      localparam bit Flip = (i == WIDTH - 1) != (j == WIDTH - 1);
      assign pp_d[i][j] = (ina[j] & inb[i]) ^ (is_signed & Flip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q   <= '{default: '0};
      sgn1_q <= 1'b0;
    end else if (en1 && in_valid) begin
      pp_q   <= pp_d;
      sgn1_q <= is_signed;
    end
  end

  // Stage 2: align rows and reduce WIDTH+1 rows to two with a chain of 3:2 compressors.
  logic [PW-1:0] rows [WIDTH+1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_rows
    assign rows[i] = PW'(pp_q[i]) << i;
  end
  assign rows[WIDTH] = sgn1_q ? Corr : '0;

  for (genvar k = 2; k <= WIDTH; k++) begin : g_csa
    logic [PW-1:0] s_in, c_in, s, c;
    logic [PW-2:0] co;

    if (k == 2) begin : g_first
      assign s_in = rows[0];
      assign c_in = rows[1];
    end else begin : g_next
      assign s_in = g_csa[k-1].s;
      assign c_in = g_csa[k-1].c;
    end

    for (genvar n = 0; n < PW - 1; n++) begin : g_col
      adder_cell u_fa (
        .a   (s_in[n]),
        .b   (c_in[n]),
        .cin (rows[k][n]),
        .sum (s[n]),
        .cout(co[n])
      );
    end
    // Carry out of the top column falls outside the 2*WIDTH product.
    assign s[PW-1] = s_in[PW-1] ^ c_in[PW-1] ^ rows[k][PW-1];
    assign c       = {co, 1'b0};
  end

  logic [PW-1:0] sum2_q, car2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum2_q <= '0;
      car2_q <= '0;
    end else if (en2 && v1_q) begin
      sum2_q <= g_csa[WIDTH].s;
      car2_q <= g_csa[WIDTH].c;
    end
  end

  // Stage 3: carry-propagate add.
  logic [PW-1:0] result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (en3 && v2_q) begin
      result_q <= sum2_q + car2_q;
    end
  end

  assign result_out = result_q;

endmodule

// File: tb/tb_pipelined_multi.sv
// Directed bench for pipelined_multi at WIDTH 8, plus 4- and 32-bit sweeps against a model.
module tb_pipelined_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        v4, r4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  res4;
  logic        v32, r32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  pipelined_multi #(.WIDTH(8), .STAGES(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .ina(a8), .inb(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .result_out(res8)
  );
  pipelined_multi #(.WIDTH(4), .STAGES(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .ina(a4), .inb(b4),
    .is_signed(s4), .out_valid(ov4), .out_ready(or4), .result_out(res4)
  );
  pipelined_multi #(.WIDTH(32), .STAGES(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .ina(a32), .inb(b32),
    .is_signed(s32), .out_valid(ov32), .out_ready(or32), .result_out(res32)
  );

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int got8 = 0, got4 = 0, got32 = 0;
  int first8 = -1, last8 = -1;
  int snap;
  int k;
  logic acc8;
  logic [63:0] q8[$], q4[$], q32[$];
  logic [7:0] bp_a [4], bp_b [4];
  logic       bp_s [4];
  logic [31:0] c32_a [4], c32_b [4];
  logic        c32_s [4];

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int w, input logic s);
    logic [63:0] ea, eb, p;
    ea = 64'(a);
    eb = 64'(b);
    if (s && a[w-1]) ea = ea | (~64'd0 << w);
    if (s && b[w-1]) eb = eb | (~64'd0 << w);
    p = ea * eb;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after inputs are driven at a falling edge; accounts for the coming rising edge.
  task automatic tick();
    #1;
    if (ov8 && or8) begin
      check("res8", 64'(res8), q8.size() != 0 ? q8.pop_front() : {64{1'bx}});
      got8++;
      if (first8 < 0) first8 = cyc;
      last8 = cyc;
    end
    if (ov4 && or4) begin
      check("res4", 64'(res4), q4.size() != 0 ? q4.pop_front() : {64{1'bx}});
      got4++;
    end
    if (ov32 && or32) begin
      check("res32", res32, q32.size() != 0 ? q32.pop_front() : {64{1'bx}});
      got32++;
    end
    acc8 = v8 && r8;
    if (v8 && r8) q8.push_back(model(32'(a8), 32'(b8), 8, s8));
    if (v4 && r4) q4.push_back(model(32'(a4), 32'(b4), 4, s4));
    if (v32 && r32) q32.push_back(model(a32, b32, 32, s32));
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bp_a = '{8'h12, 8'h85, 8'h7F, 8'hC8};
    bp_b = '{8'h34, 8'h03, 8'h81, 8'hC8};
    bp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    c32_a = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    c32_b = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    c32_s = '{1'b1, 1'b0, 1'b1, 1'b1};
    {v8, a8, b8, s8} = '0;
    {v4, a4, b4, s4} = '0;
    {v32, a32, b32, s32} = '0;
    or8 = 1'b1; or4 = 1'b1; or32 = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_result", 64'(res8), 64'd0);
    check("rst_in_ready", 64'(r8), 64'd1);
    rst_n = 1'b1;
    #1 check("release_in_ready", 64'(r8), 64'd1);

    // Signed min*min: valid appears after the third rising edge counting the accept edge
    a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    check("lat_edge1", 64'(ov8), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(ov8), 64'd0);
    @(negedge clk);
    check("lat_edge3_valid", 64'(ov8), 64'd1);
    check("signed_min_min", 64'(res8), 64'h4000);
    @(negedge clk);
    check("lat_drained", 64'(ov8), 64'd0);

    // Mixed modes back to back
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; s8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    check("mixed_u_valid", 64'(ov8), 64'd1);
    check("unsigned_ff_ff", 64'(res8), 64'hFE01);
    @(negedge clk);
    check("mixed_s_valid", 64'(ov8), 64'd1);
    check("signed_ff_01", 64'(res8), 64'hFFFF);
    @(negedge clk);

    // 16 random back-to-back operations at full throughput
    got8 = 0;
    for (int i = 0; i < 16; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(1, 0)); v8 = 1'b1;
      tick();
    end
    v8 = 1'b0;
    repeat (6) tick();
    check("stream_count", 64'(got8), 64'd16);
    check("stream_spacing", 64'(last8 - first8), 64'd15);

    // Backpressure: out_ready low for five cycles while feeding four operations
    or8 = 1'b0;
    k = 0;
    a8 = bp_a[0]; b8 = bp_b[0]; s8 = bp_s[0]; v8 = 1'b1;
    snap = got8;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc8) begin
        k++;
        if (k < 4) begin a8 = bp_a[k]; b8 = bp_b[k]; s8 = bp_s[k]; end
        else v8 = 1'b0;
      end
    end
    check("bp_accepts", 64'(k), 64'd3);
    check("bp_in_ready_low", 64'(r8), 64'd0);
    check("bp_out_valid", 64'(ov8), 64'd1);
    check("bp_held_result", 64'(res8), 64'h03A8);
    tick();
    check("bp_still_valid", 64'(ov8), 64'd1);
    check("bp_still_held", 64'(res8), 64'h03A8);
    // Releasing out_ready on a full pipeline frees a slot in the same cycle
    or8 = 1'b1;
    #1 check("full_drain_ready", 64'(r8), 64'd1);
    tick();
    check("bp_fourth_accept", 64'(acc8), 64'd1);
    v8 = 1'b0;
    repeat (6) tick();
    check("bp_all_out", 64'(got8 - snap), 64'd4);
    check("bp_queue_empty", 64'(q8.size()), 64'd0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(8'h10 + i); b8 = 8'h11; s8 = 1'b0; v8 = 1'b1;
      tick();
    end
    v8 = 1'b0;
    check("pre_reset_valid", 64'(ov8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", 64'(ov8), 64'd0);
    check("reset_result", 64'(res8), 64'd0);
    check("reset_in_ready", 64'(r8), 64'd1);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    snap = got8;
    repeat (6) tick();
    check("no_stale_results", 64'(got8 - snap), 64'd0);
    a8 = 8'h7F; b8 = 8'h7F; s8 = 1'b1; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    check("post_reset_valid", 64'(ov8), 64'd1);
    check("post_reset_result", 64'(res8), 64'h3F01);
    tick();

    // WIDTH=4 exhaustive in both modes, WIDTH=32 corners plus random
    got4 = 0;
    got32 = 0;
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; s4 = i[8]; v4 = 1'b1;
      if (i < 4) begin
        a32 = c32_a[i]; b32 = c32_b[i]; s32 = c32_s[i]; v32 = 1'b1;
      end else if (i < 40) begin
        a32 = $urandom; b32 = $urandom; s32 = 1'($urandom_range(1, 0)); v32 = 1'b1;
      end else begin
        v32 = 1'b0;
      end
      tick();
    end
    v4 = 1'b0;
    v32 = 1'b0;
    repeat (6) tick();
    check("w4_count", 64'(got4), 64'd512);
    check("w32_count", 64'(got32), 64'd40);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipelined_multi.md
PIPELINED_MULTI -- requirements
Module: pipelined_multi

Interface
REQ-001 Parameter WIDTH, 8, operand width in bits; legal range 4..32.
REQ-002 Parameter STAGES, 3, pipeline depth; fixed at 3 (partial products / compression tree / final add); other values rejected at elaboration.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port in_valid  input  1  operands present.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port ina  input  WIDTH  multiplicand.
REQ-008 Port inb  input  WIDTH  multiplier.
REQ-009 Port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-010 Port out_valid  output  1  result present.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port result_out  output  2*WIDTH  product.

Function
REQ-013 Transfer in occurs on rising edge with in_valid && in_ready; transfer out with out_valid && out_ready.
REQ-014 result_out SHALL equal ina*inb, full 2*WIDTH bits, no truncation or saturation; signed mode via Baugh-Wooley sign correction, unsigned mode with zero extension.
REQ-015 is_signed SHALL travel with its operands; mixed modes back-to-back SHALL each produce their own correct result.
REQ-016 Latency without stall: exactly 3 cycles from input transfer edge to out_valid high.
REQ-017 Throughput: one operation per cycle when out_ready held high.
REQ-018 Each stage holds a valid bit; a stage loads when it is empty or its contents move forward in the same cycle.
REQ-019 in_ready = !stage1_valid || stage1 advancing; in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 No combinational path from ina/inb/is_signed to result_out or out_valid.
REQ-021 Backpressure (out_ready low with out_valid high): result_out and out_valid SHALL hold stable; upstream stages fill, then in_ready drops; no operation lost or duplicated.
REQ-022 Full pipeline, out_ready rising: result drains and a new input SHALL be accepted in the same cycle.
REQ-023 Empty pipeline: out_valid low; result_out holds last value (don't-care for checking).
REQ-024 Stage 1: WIDTH x WIDTH AND array plus sign-correction terms registered; stage 2: carry-save reduction to two rows registered; stage 3: carry-propagate add registered.

Reset
REQ-025 rst_n low SHALL asynchronously clear all stage valid bits, out_valid to 0, result_out to 0, in_ready to 1 after release.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-027 Reset release synchronous to clk; first acceptance possible on first rising edge with rst_n high.

Structure
REQ-028 Shared package mult_pkg holds WIDTH default, WIDTH bounds and the stage-count constant.
REQ-029 Full adder cell adder_cell (a, b, cin -> sum, cout) is the single instantiated sub-module, used generatively in the compression tree.
REQ-030 Reduction tree generated from WIDTH; no hand-enumerated per-column instances.

Verification
REQ-031 WIDTH=8, signed, ina=0x80, inb=0x80 -> result_out 0x4000 three cycles later.
REQ-032 WIDTH=8, unsigned 0xFF*0xFF -> 0xFE01; then signed 0xFF*0x01 next cycle -> 0xFFFF one cycle after.
REQ-033 Back-to-back 16 random ops, out_ready=1 -> 16 results in order, one per cycle, matching reference model.
REQ-034 out_ready low 5 cycles while feeding -> in_ready low after 3 accepts plus held output; results intact and ordered after release.
REQ-035 rst_n pulsed low with 3 ops in flight -> out_valid 0 immediately, no stale results after release, next op correct.
REQ-036 WIDTH=4 and WIDTH=32 exhaustive/random sweeps both modes, including min*min and max*max -> exact products.
